// File: rtl/host_slave_mux_pkg.sv
// Shared constants and helpers for the host/slave mode controller.
// Register map, default version value and the reset counter width function.
package host_slave_mux_pkg;

  localparam logic [1:0] MODE_ADDR    = 2'd0;
  localparam logic [1:0] RST_ADDR     = 2'd1;
  localparam logic [1:0] CHGCNT_ADDR  = 2'd2;
  localparam logic [1:0] VERSION_ADDR = 2'd3;

  localparam logic [7:0] DEFAULT_VERSION = 8'h23;

  // Smallest width that can hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd31; i++) begin
      if ((32'd1 << i) < value) begin
        width = i + 32'd1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/port_rst_stretch.sv
// One port's soft-reset stretcher: a reloadable down-counter with a registered
// active-high reset output that is high while the count is non-zero.
module port_rst_stretch
  import host_slave_mux_pkg::*;
#(
  parameter int RST_LEN = 6
) (
  input  logic busClk,
  input  logic rstSyncToBusClk,
  input  logic trigger,
  output logic portRst
);

  localparam int unsigned CW = clog2(RST_LEN + 1);
  localparam logic [CW-1:0] LOAD = CW'(RST_LEN);

  logic [CW-1:0] count_q, count_d;
  logic          rst_q, rst_d;

  // Next count: a trigger always reloads, so a retrigger can only extend the reset.
  always_comb begin
    count_d = count_q;
    if (trigger) begin
      count_d = LOAD;
    end else if (count_q != {CW{1'b0}}) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    rst_d = (count_d != {CW{1'b0}});
  end

  // Counter and output flag; reset reloads so every port gets a full-length reset.
  always_ff @(posedge busClk or posedge rstSyncToBusClk) begin
    if (rstSyncToBusClk) begin
      count_q <= LOAD;
      rst_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      rst_q   <= rst_d;
    end
  end

  assign portRst = rst_q;

endmodule

// File: rtl/host_slave_mux_ctrl.sv
// Bus-side register window holding per-port host/slave mode bits, a mode change
// counter and a version register; drives one reset stretcher per port.
module host_slave_mux_ctrl
  import host_slave_mux_pkg::*;
#(
  parameter int         NUM_PORTS = 2,
  parameter int         RST_LEN   = 6,
  parameter logic [7:0] VERSION   = DEFAULT_VERSION
) (
  input  logic                 busClk,
  input  logic                 rstSyncToBusClk,
  input  logic [7:0]           dataIn,
  input  logic [1:0]           address,
  input  logic                 writeEn,
  input  logic                 strobe_i,
  input  logic                 hostSlaveMuxSel,
  output logic [7:0]           dataOut,
  output logic                 ack_o,
  output logic [NUM_PORTS-1:0] hostMode,
  output logic [NUM_PORTS-1:0] portRst
);

  logic [NUM_PORTS-1:0] hostMode_q, hostMode_d;
  logic [7:0]           chgcnt_q, chgcnt_d;
  logic                 ack_q, ack_d;
  logic                 access_s, wr_s, mode_wr_s, rst_wr_s, cnt_wr_s;
  logic [NUM_PORTS-1:0] mode_chg_s, trigger_s, portRst_s;
  logic                 unused_data_s;

  // Only the low NUM_PORTS data bits carry meaning for MODE and RESET.
  assign unused_data_s = ^dataIn;

  // Register decode, change detection and next-state for MODE/CHGCNT/ack.
  always_comb begin
    access_s   = strobe_i & hostSlaveMuxSel;
    wr_s       = access_s & writeEn;
    mode_wr_s  = wr_s & (address == MODE_ADDR);
    rst_wr_s   = wr_s & (address == RST_ADDR);
    cnt_wr_s   = wr_s & (address == CHGCNT_ADDR);
    hostMode_d = hostMode_q;
    mode_chg_s = {NUM_PORTS{1'b0}};
    if (mode_wr_s) begin
      hostMode_d = dataIn[NUM_PORTS-1:0];
      mode_chg_s = dataIn[NUM_PORTS-1:0] ^ hostMode_q;
    end else begin
      hostMode_d = hostMode_q;
      mode_chg_s = {NUM_PORTS{1'b0}};
    end
    if (rst_wr_s) begin
      trigger_s = mode_chg_s | dataIn[NUM_PORTS-1:0];
    end else begin
      trigger_s = mode_chg_s;
    end
    if (cnt_wr_s) begin
      chgcnt_d = 8'h00;
    end else if (|mode_chg_s) begin
      chgcnt_d = chgcnt_q + 8'h01;
    end else begin
      chgcnt_d = chgcnt_q;
    end
    ack_d = access_s;
  end

  // Mode, change counter and acknowledge registers.
  always_ff @(posedge busClk or posedge rstSyncToBusClk) begin
    if (rstSyncToBusClk) begin
      hostMode_q <= {NUM_PORTS{1'b0}};
      chgcnt_q   <= 8'h00;
      ack_q      <= 1'b0;
    end else begin
      hostMode_q <= hostMode_d;
      chgcnt_q   <= chgcnt_d;
      ack_q      <= ack_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_rst_stretch #(
      .RST_LEN(RST_LEN)
    ) u_stretch (
      .busClk         (busClk),
      .rstSyncToBusClk(rstSyncToBusClk),
      .trigger        (trigger_s[p]),
      .portRst        (portRst_s[p])
    );
  end

  // Read mux, independent of strobe.
  always_comb begin
    dataOut = 8'h00;
    case (address)
      MODE_ADDR:    dataOut[NUM_PORTS-1:0] = hostMode_q;
      RST_ADDR:     dataOut[NUM_PORTS-1:0] = portRst_s;
      CHGCNT_ADDR:  dataOut = chgcnt_q;
      VERSION_ADDR: dataOut = VERSION;
      default:      dataOut = 8'h00;
    endcase
  end

  assign ack_o    = ack_q;
  assign hostMode = hostMode_q;
  assign portRst  = portRst_s;

endmodule

// File: tb/tb_host_slave_mux_ctrl.sv
// Scoreboard bench for host_slave_mux_ctrl: a time-based reference model queues
// expected bus responses; a negedge monitor checks ack, read data, mode and resets.
module tb_host_slave_mux_ctrl;

  localparam int         NP  = 2;
  localparam int         RL  = 6;
  localparam logic [7:0] VER = 8'h23;

  logic          busClk = 1'b0;
  logic          rst;
  logic [7:0]    dataIn;
  logic [1:0]    address;
  logic          writeEn;
  logic          strobe_i;
  logic          hostSlaveMuxSel;
  logic [7:0]    dataOut;
  logic          ack_o;
  logic [NP-1:0] hostMode;
  logic [NP-1:0] portRst;

  host_slave_mux_ctrl #(.NUM_PORTS(NP), .RST_LEN(RL), .VERSION(VER)) dut (
    .busClk         (busClk),
    .rstSyncToBusClk(rst),
    .dataIn         (dataIn),
    .address        (address),
    .writeEn        (writeEn),
    .strobe_i       (strobe_i),
    .hostSlaveMuxSel(hostSlaveMuxSel),
    .dataOut        (dataOut),
    .ack_o          (ack_o),
    .hostMode       (hostMode),
    .portRst        (portRst)
  );

  always #5 busClk = ~busClk;

  typedef struct {
    logic       is_rd;
    logic [1:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: edge index, mode bits, change count, and the edge at which each port reset ends.
  int            m_edge = 0;
  logic [NP-1:0] m_mode = '0;
  logic [7:0]    m_cnt  = 8'h00;
  int            m_until[NP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: each port is in reset until a known edge; triggers push that edge out.
  always @(posedge busClk) begin : model
    int            k;
    logic [NP-1:0] nm;
    logic [7:0]    nc;
    int            nu[NP];
    logic [7:0]    rd;
    exp_t          it;
    k  = m_edge + 1;
    nm = m_mode;
    nc = m_cnt;
    nu = m_until;
    if (rst) begin
      nm = '0;
      nc = 8'h00;
      for (int p = 0; p < NP; p++) nu[p] = k + RL;
    end else if (strobe_i && hostSlaveMuxSel) begin
      if (writeEn) begin
        case (address)
          2'd0: begin
            if (dataIn[NP-1:0] != m_mode) nc = nc + 8'h01;
            for (int p = 0; p < NP; p++)
              if (dataIn[p] != m_mode[p]) nu[p] = (nu[p] > k + RL) ? nu[p] : k + RL;
            nm = dataIn[NP-1:0];
          end
          2'd1: begin
            for (int p = 0; p < NP; p++)
              if (dataIn[p]) nu[p] = (nu[p] > k + RL) ? nu[p] : k + RL;
          end
          2'd2: nc = 8'h00;
          default: ;
        endcase
      end
      rd = 8'h00;
      case (address)
        2'd0: rd[NP-1:0] = nm;
        2'd1: for (int p = 0; p < NP; p++) rd[p] = (k < nu[p]);
        2'd2: rd = nc;
        default: rd = VER;
      endcase
      it.is_rd = !writeEn;
      it.addr  = address;
      it.data  = rd;
      exp_q.push_back(it);
    end
    m_edge  <= k;
    m_mode  <= nm;
    m_cnt   <= nc;
    m_until <= nu;
  end

  // Monitor: every cycle check resets and mode; on ack pop and compare the response.
  always @(negedge busClk) begin : monitor
    logic [NP-1:0] ep;
    exp_t          it;
    if ($time > 2) begin
      if (rst) begin
        chk("reset_portRst", 32'(portRst), 32'({NP{1'b1}}));
        chk("reset_hostMode", 32'(hostMode), 32'd0);
        chk("reset_ack", 32'(ack_o), 32'd0);
        exp_q.delete();
      end else begin
        for (int p = 0; p < NP; p++) ep[p] = (m_edge < m_until[p]);
        chk("portRst", 32'(portRst), 32'(ep));
        chk("hostMode", 32'(hostMode), 32'(m_mode));
        if (exp_q.size() > 0) begin
          it = exp_q.pop_front();
          chk("ack_expected", 32'(ack_o), 32'd1);
          if (it.is_rd) chk($sformatf("read_addr%0d", it.addr), 32'(dataOut), 32'(it.data));
        end else begin
          chk("ack_idle", 32'(ack_o), 32'd0);
        end
      end
    end
  end

  // One access cycle followed by one idle cycle with the address held for the read check.
  task automatic bus(input logic sel, input logic we, input logic [1:0] a, input logic [7:0] d);
    @(posedge busClk);
    #1;
    hostSlaveMuxSel = sel;
    strobe_i        = 1'b1;
    writeEn         = we;
    address         = a;
    dataIn          = d;
    @(posedge busClk);
    #1;
    strobe_i        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge busClk);
    #1;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) m_until[p] = 0;
    rst             = 1'b0;
    strobe_i        = 1'b0;
    hostSlaveMuxSel = 1'b0;
    writeEn         = 1'b0;
    address         = 2'd0;
    dataIn          = 8'h00;
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(RL + 3);
    bus(1'b1, 1'b0, 2'd0, 8'h00);
    bus(1'b1, 1'b0, 2'd3, 8'h00);

    // Staggered mode changes, then a no-op rewrite.
    bus(1'b1, 1'b1, 2'd0, 8'h01);
    bus(1'b1, 1'b1, 2'd0, 8'h03);
    bus(1'b1, 1'b0, 2'd2, 8'h00);
    idle(RL + 2);
    bus(1'b1, 1'b1, 2'd0, 8'hF3);
    bus(1'b1, 1'b0, 2'd2, 8'h00);
    bus(1'b1, 1'b0, 2'd0, 8'h00);

    // Explicit reset, retriggered three cycles later, read back while active.
    idle(RL + 2);
    bus(1'b1, 1'b1, 2'd1, 8'h02);
    @(posedge busClk);
    bus(1'b1, 1'b1, 2'd1, 8'h02);
    bus(1'b1, 1'b0, 2'd1, 8'h00);
    idle(RL + 4);

    // Change counter wrap and clear.
    bus(1'b1, 1'b1, 2'd2, 8'h5A);
    for (int i = 0; i < 256; i++) bus(1'b1, 1'b1, 2'd0, (i % 2 == 0) ? 8'h00 : 8'h03);
    bus(1'b1, 1'b0, 2'd2, 8'h00);
    bus(1'b1, 1'b1, 2'd2, 8'hFF);
    bus(1'b1, 1'b0, 2'd2, 8'h00);
    bus(1'b1, 1'b1, 2'd3, 8'h77);
    bus(1'b1, 1'b0, 2'd3, 8'h00);

    // Three back-to-back reads.
    idle(RL + 2);
    hostSlaveMuxSel = 1'b1;
    strobe_i        = 1'b1;
    writeEn         = 1'b0;
    address         = 2'd3;
    idle(3);
    strobe_i = 1'b0;
    idle(3);

    // Randomized traffic including deselected strobes.
    for (int i = 0; i < 200; i++) begin
      bus(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(RL + 2);

    // Asynchronous reset with two counts remaining on port 0.
    bus(1'b1, 1'b1, 2'd1, 8'h01);
    repeat (4) @(posedge busClk);
    #1 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(RL + 4);
    bus(1'b1, 1'b0, 2'd0, 8'h00);
    bus(1'b1, 1'b0, 2'd2, 8'h00);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/host_slave_mux_ctrl.md
# host_slave_mux_ctrl

Parametrised host/slave mode controller for the USB core, driving NUM_PORTS independent USB ports from one bus-side register window. It holds a per-port host/slave mode bit and produces a per-port soft reset of programmable length. That reset fires automatically on power-up, on any mode change, and on explicit software request. A change counter and a version register provide software visibility. The block sits in the busClk domain; each portRst is re-synchronised into its usbClk domain by the port logic downstream.

## Interface
Parameters:
- NUM_PORTS, 2, number of USB ports controlled (1..8)
- RST_LEN, 6, busClk cycles each port reset is held (2..255)
- VERSION, 8'h23, value returned at the VERSION address

Ports:
- busClk  in  1  bus clock; the only clock of the block
- rstSyncToBusClk  in  1  reset, asynchronous, active-high
- dataIn  in  8  write data
- address  in  2  register select: 0 MODE, 1 RESET, 2 CHGCNT, 3 VERSION
- writeEn  in  1  1 = write, 0 = read
- strobe_i  in  1  bus cycle valid
- hostSlaveMuxSel  in  1  block select
- dataOut  out  8  read data, combinational from address
- ack_o  out  1  bus acknowledge, registered
- hostMode  out  NUM_PORTS  per-port mode: 1 = host, 0 = slave
- portRst  out  NUM_PORTS  per-port soft reset, active-high

## Operation
- A bus access occurs on any cycle with strobe_i & hostSlaveMuxSel. A write is an access with writeEn = 1.
- MODE write:
  - hostMode[p] <= dataIn[p] for every p < NUM_PORTS.
  - Every port whose bit changes value starts a reset sequence.
  - Upper data bits are ignored.
- MODE read: {zeros, hostMode}.
- RESET write: each port p with dataIn[p] = 1 starts a reset sequence. 0 bits have no effect.
- RESET read: {zeros, portRst}. A set bit means that port's reset is still in progress.
- CHGCNT: an 8-bit counter.
  - It increments on each MODE write that changes at least one bit.
  - It wraps 255 -> 0.
  - A write of any data clears it to 0.
  - If a clear and an increment are requested in the same cycle, the clear wins. This cannot happen through the single-address bus; it is stated for completeness.
- VERSION read returns VERSION. Writes to VERSION are ignored but still acknowledged.
- Reset sequence, per port:
  - A down-counter of width clog2(RST_LEN+1) is loaded with RST_LEN.
  - portRst[p] = (count != 0), registered.
  - The counter decrements to 0 and then holds.
  - A retrigger while the counter is running reloads it to RST_LEN, which extends the reset. Triggers never shorten a running reset.
- Rules for dataOut:
  - dataOut is valid for any address regardless of strobe.
  - Unused high bits read 0.

## Timing
- Values during and after asynchronous reset:
  - hostMode = 0, CHGCNT = 0, ack_o = 0.
  - All reset counters = RST_LEN, so portRst = all ones.
- After reset deasserts, portRst stays high for exactly RST_LEN busClk edges, then falls.
- For a write at edge N:
  - hostMode and CHGCNT update at edge N.
  - portRst rises at edge N (the counter is loaded) and is high for RST_LEN cycles, falling at edge N+RST_LEN.
- ack_o is high for the one cycle following each access cycle. Back-to-back accesses give a continuous ack_o.
- A MODE write that sets a value equal to the current one has no side effects: no reset, no count.
- An asynchronous reset in the middle of a sequence reloads every counter to RST_LEN, which gives a full-length reset after release.

## Structure
- Package host_slave_mux_pkg holds:
  - address constants MODE_ADDR=0, RST_ADDR=1, CHGCNT_ADDR=2, VERSION_ADDR=3;
  - default VERSION;
  - a clog2 width function for the counter width.
- Sub-module port_rst_stretch holds one counter with its output register. Parameter RST_LEN; ports busClk, rstSyncToBusClk, trigger, portRst. It is instantiated NUM_PORTS times through a generate loop.
- The top level contains the register decode, the MODE/CHGCNT registers, the change-detect XOR, the ack register and the read mux.

## Test plan
- Power-up, NUM_PORTS=2, RST_LEN=6: release reset -> portRst=2'b11 for exactly 6 cycles, then 2'b00; hostMode=0; MODE read = 8'h00; VERSION read = 8'h23.
- MODE write 8'h01, then 8'h03 two cycles later:
  - port0's reset starts at the first write;
  - port1's reset starts at the second;
  - port0's reset is not retriggered;
  - CHGCNT reads 2.
- MODE write 8'h03 when hostMode is already 2'b11 -> no portRst; CHGCNT unchanged.
- RESET write 8'h02 at cycle N, then again at N+3 -> portRst[1] high from N through N+8 (extended); portRst[0] stays low; RESET reads 8'h02 while the reset is active.
- 256 toggling MODE writes -> CHGCNT wraps to 0; a CHGCNT write of 8'hFF then reads 0.
- Assert reset while a port reset is counting at 2 remaining -> after release, portRst is all ones for a full RST_LEN cycles. Also check ack_o is a single cycle per access and continuous for 3 back-to-back strobes.
